spi_controller: RTL and testbench

- SPI initiator that drives the register-write protocol served by the design's SPI peripheral: nCS, SCLK, COPI out; CIPO in.
- Takes one request at a time on a valid/ready port and serializes a 16-bit frame MSB first: R/W bit, 7-bit address, 8-bit data. Mode 0.
- Used as the bench-side and FPGA-side master that programs the output-enable, PWM-enable and duty-cycle registers.
- Also captures CIPO during the data phase so a future readable peripheral can be exercised.

---
 rtl/spi_pkg.sv | 38 +++
 rtl/spi_ctrl_tick.sv | 29 ++
 rtl/spi_controller.sv | 158 +++++++++++++++
 tb/tb_spi_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared frame geometry, peripheral register map and controller state type
// for the SPI register-write initiator.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int RW_BIT  = 15;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0   = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8  = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0   = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8  = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY     = 7'h04;

  // state    | meaning
  // ST_IDLE  | ncs high, ready for a request
  // ST_SETUP | ncs low, first bit on copi, sclk low for one half-period
  // ST_SHIFT | sclk toggling, 16 rising edges
  // ST_HOLD  | sclk low after the last falling edge, ncs still low
  // ST_GAP   | ncs high, minimum inter-frame spacing
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic              wr,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {wr, addr, data};
  endfunction

endpackage

// File: rtl/spi_ctrl_tick.sv
// Half-period timebase: counts 0..CLK_DIV-1 and flags the terminal count,
// so the tick fires on every CLK_DIV-th cycle after a clear.
module spi_ctrl_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == TC) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == TC);

endmodule

// File: rtl/spi_controller.sv
// Mode-0 SPI initiator: one 16-bit {rw, addr, data} frame per accepted
// request, MSB first, with CIPO captured on every rising SCLK edge.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rsp_data,
  output logic              sclk,
  output logic              copi,
  output logic              ncs,
  input  logic              cipo
);

  localparam int BIT_W = $clog2(FRAME_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  spi_state_t r_state;
  spi_state_t w_next;

  logic               w_tick;
  logic               w_tick_clr;
  logic               w_accept;
  logic               w_last_fall;
  logic [FRAME_W-1:0] w_frame;

  logic [FRAME_W-2:0] r_tx;
  logic [DATA_W-1:0]  r_rx;
  logic [DATA_W-1:0]  r_rsp;
  logic [BIT_W-1:0]   r_bit;
  logic [7:0]         r_gap;
  logic               r_sclk;
  logic               r_copi;
  logic               r_ncs;
  logic               r_done;
  logic               r_ready;

  assign w_frame     = pack_frame(req_write, req_addr, req_data);
  assign w_accept    = req_valid && r_ready;
  // Holding the timebase in reset while idle aligns every frame's ticks to acceptance.
  assign w_tick_clr  = (r_state == ST_IDLE);
  assign w_last_fall = (r_state == ST_SHIFT) && w_tick && r_sclk && (r_bit == LAST_BIT);

  spi_ctrl_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)    w_next = ST_SETUP;
      ST_SETUP: if (w_tick)      w_next = ST_SHIFT;
      ST_SHIFT: if (w_last_fall) w_next = ST_HOLD;
      ST_HOLD:  if (w_tick)      w_next = ST_GAP;
      ST_GAP:   if (r_gap == '0) w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx    <= '0;
      r_rx    <= '0;
      r_rsp   <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_sclk  <= 1'b0;
      r_copi  <= 1'b0;
      r_ncs   <= 1'b1;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_next == ST_IDLE);
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_copi <= w_frame[RW_BIT];
            r_tx   <= w_frame[RW_BIT-1:0];
            r_ncs  <= 1'b0;
            r_sclk <= 1'b0;
            r_bit  <= '0;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_sclk <= 1'b1;
            r_rx   <= {r_rx[DATA_W-2:0], cipo};
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[DATA_W-2:0], cipo};
            end else begin
              r_sclk <= 1'b0;
              // The final falling edge leaves copi on bit 0 through HOLD.
              if (r_bit != LAST_BIT) begin
                r_bit  <= r_bit + BIT_W'(1);
                r_copi <= r_tx[FRAME_W-2];
                r_tx   <= {r_tx[FRAME_W-3:0], 1'b0};
              end
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_ncs  <= 1'b1;
            r_copi <= 1'b0;
            r_done <= 1'b1;
            r_rsp  <= r_rx;
            r_gap  <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign rsp_data  = r_rsp;
  assign sclk      = r_sclk;
  assign copi      = r_copi;
  assign ncs       = r_ncs;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench: two controllers (CLK_DIV=4/GAP=4 and CLK_DIV=2/GAP=1)
// compared cycle by cycle against an arithmetic waveform model of the frame.
module tb_spi_controller;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] valid;
  logic [1:0] req_w;
  logic [1:0] cipo;
  logic [6:0] req_a [2];
  logic [7:0] req_d [2];

  wire  [1:0] ready_w, busy_w, done_w, sclk_w, copi_w, ncs_w;
  wire  [7:0] rsp_w [2];

  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;
  logic [7:0]  last_rsp  [2];
  int unsigned last_rise [2];
  logic [7:0]  periph [128];

  spi_controller #(.CLK_DIV(4), .GAP_CYCLES(4)) u_dut_d4 (
    .clk(clk), .rst(rst),
    .req_valid(valid[0]), .req_ready(ready_w[0]),
    .req_write(req_w[0]), .req_addr(req_a[0]), .req_data(req_d[0]),
    .busy(busy_w[0]), .done(done_w[0]), .rsp_data(rsp_w[0]),
    .sclk(sclk_w[0]), .copi(copi_w[0]), .ncs(ncs_w[0]), .cipo(cipo[0])
  );

  spi_controller #(.CLK_DIV(2), .GAP_CYCLES(1)) u_dut_d2 (
    .clk(clk), .rst(rst),
    .req_valid(valid[1]), .req_ready(ready_w[1]),
    .req_write(req_w[1]), .req_addr(req_a[1]), .req_data(req_d[1]),
    .busy(busy_w[1]), .done(done_w[1]), .rsp_data(rsp_w[1]),
    .sclk(sclk_w[1]), .copi(copi_w[1]), .ncs(ncs_w[1]), .cipo(cipo[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full frame on controller `sel`; pat is the CIPO bit per frame bit.
  task automatic run_frame(input int sel, input logic w, input logic [6:0] a,
                           input logic [7:0] d, input logic [15:0] pat,
                           input logic keep, input logic [15:0] nxt, input logic chk_gap);
    int dv, gp, n, lim, idx, rises, falls, low_len, done_n;
    int wave_err, ncs_err, copi_err, done_err, busy_err;
    logic [15:0] frame, bits;
    logic [7:0]  got_rsp;
    logic        ps, pn, s, nc, cp, dn, by, rd, exp_s, exp_c, exp_n;
    dv    = (sel == 0) ? 4 : 2;
    gp    = (sel == 0) ? 4 : 1;
    frame = {w, a, d};
    req_w[sel] = w; req_a[sel] = a; req_d[sel] = d;
    cipo[sel]  = pat[15];
    valid[sel] = 1'b1;
    n = 0;
    while (ready_w[sel] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      chk("accept_timeout", 32'd0, 32'd1);
      valid[sel] = 1'b0;
      return;
    end
    chk("rsp_hold", 32'(rsp_w[sel]), 32'(last_rsp[sel]));
    @(posedge clk);
    #1;
    if (keep) begin
      {req_w[sel], req_a[sel], req_d[sel]} = nxt;
    end else begin
      valid[sel] = 1'b0;
      {req_w[sel], req_a[sel], req_d[sel]} = 16'($urandom);
    end
    rises = 0; falls = 0; low_len = 0; done_n = 0;
    wave_err = 0; ncs_err = 0; copi_err = 0; done_err = 0; busy_err = 0;
    bits = '0; got_rsp = ~pat[7:0]; ps = 1'b0; pn = 1'b1;
    lim = 33 * dv + 2;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      s = sclk_w[sel]; nc = ncs_w[sel]; cp = copi_w[sel];
      dn = done_w[sel]; by = busy_w[sel]; rd = ready_w[sel];
      if (c == 1 && chk_gap) chk("gap_len", cyc - last_rise[sel], 32'(gp + 1));
      exp_s = (c >= 1 + dv && c <= 32 * dv) ? (((c - 1 - dv) / dv) % 2 == 0) : 1'b0;
      exp_n = (c > 33 * dv);
      if (c <= 33 * dv) begin
        idx = (c - 1) / (2 * dv);
        if (idx > 15) idx = 15;
        exp_c = frame[15 - idx];
      end else begin
        exp_c = 1'b0;
      end
      if (s !== exp_s) wave_err++;
      if (nc !== exp_n) ncs_err++;
      if (cp !== exp_c) copi_err++;
      if (dn !== (c == 33 * dv + 1)) done_err++;
      if (c <= 33 * dv + 1 && (by !== 1'b1 || rd !== 1'b0)) busy_err++;
      if (nc === 1'b0) low_len++;
      if (s && !ps) begin
        bits = {bits[14:0], cp};
        rises++;
      end
      if (!s && ps) begin
        falls++;
        if (falls <= 15) cipo[sel] = pat[15 - falls];
      end
      if (dn) begin
        done_n++;
        got_rsp = rsp_w[sel];
      end
      if (!pn && nc) last_rise[sel] = cyc;
      ps = s; pn = nc;
    end
    chk("frame_bits", 32'(bits), 32'(frame));
    chk("sclk_rises", rises, 16);
    chk("ncs_low_len", low_len, 33 * dv);
    chk("sclk_wave_err", wave_err, 0);
    chk("ncs_wave_err", ncs_err, 0);
    chk("copi_wave_err", copi_err, 0);
    chk("done_count", done_n, 1);
    chk("done_timing_err", done_err, 0);
    chk("busy_ready_err", busy_err, 0);
    chk("rsp_data", 32'(got_rsp), 32'(pat[7:0]));
    last_rsp[sel] = pat[7:0];
    if (bits[15]) periph[bits[14:8]] = bits[7:0];
  endtask

  task automatic reset_mid_frame();
    int n, rises, done_n, high_err;
    logic ps;
    req_w[0] = 1'b1; req_a[0] = ADDR_EN_PWM_7_0; req_d[0] = 8'h3C;
    valid[0] = 1'b1;
    n = 0;
    while (ready_w[0] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 valid[0] = 1'b0;
    rises = 0; ps = 1'b0; n = 0;
    while (rises < 5 && n < 400) begin
      @(negedge clk);
      if (sclk_w[0] && !ps) rises++;
      ps = sclk_w[0];
      n++;
    end
    chk("rst_rise5_seen", rises, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ncs", 32'(ncs_w[0]), 32'd1);
    chk("rst_mid_sclk", 32'(sclk_w[0]), 32'd0);
    chk("rst_mid_done", 32'(done_w[0]), 32'd0);
    chk("rst_mid_ready", 32'(ready_w[0]), 32'd0);
    chk("rst_mid_busy", 32'(busy_w[0]), 32'd0);
    rst = 1'b0;
    last_rsp[0] = 8'h00;
    last_rsp[1] = 8'h00;
    @(negedge clk);
    chk("rst_mid_ready_after", 32'(ready_w[0]), 32'd1);
    done_n = 0; high_err = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_w[0]) done_n++;
      if (ncs_w[0] !== 1'b1 || sclk_w[0] !== 1'b0) high_err++;
    end
    chk("rst_mid_no_done", done_n, 0);
    chk("rst_mid_idle_lines", high_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] pat;
    int sel;
    valid = '0; req_w = '0; cipo = '0;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = '0; req_d[i] = '0; last_rsp[i] = '0; last_rise[i] = 0;
    end
    for (int i = 0; i < 128; i++) periph[i] = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ncs", 32'(ncs_w[i]), 32'd1);
      chk("rst_sclk", 32'(sclk_w[i]), 32'd0);
      chk("rst_copi", 32'(copi_w[i]), 32'd0);
      chk("rst_done", 32'(done_w[i]), 32'd0);
      chk("rst_busy", 32'(busy_w[i]), 32'd0);
      chk("rst_rsp", 32'(rsp_w[i]), 32'd0);
      chk("rst_ready", 32'(ready_w[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst_d4", 32'(ready_w[0]), 32'd1);
    chk("ready_after_rst_d2", 32'(ready_w[1]), 32'd1);

    // basic write 0x80F0
    run_frame(0, 1'b1, ADDR_EN_OUT_7_0, 8'hF0, 16'($urandom), 1'b0, 16'h0, 1'b0);
    // duty-cycle write reaches the receiving register model
    run_frame(0, 1'b1, ADDR_PWM_DUTY, 8'h80, 16'($urandom), 1'b0, 16'h0, 1'b0);
    chk("pwm_duty_reg", 32'(periph[ADDR_PWM_DUTY]), 32'h80);
    // read capture: low byte 0xA5 from the peripheral
    run_frame(0, 1'b0, ADDR_PWM_DUTY, 8'h00, {8'h5E, 8'hA5}, 1'b0, 16'h0, 1'b0);
    // back-to-back with req_valid held high
    run_frame(0, 1'b1, ADDR_EN_OUT_15_8, 8'h5A, 16'($urandom), 1'b1,
              {1'b1, ADDR_EN_PWM_15_8, 8'hC3}, 1'b0);
    run_frame(0, 1'b1, ADDR_EN_PWM_15_8, 8'hC3, 16'($urandom), 1'b0, 16'h0, 1'b1);
    chk("periph_en_out_15_8", 32'(periph[ADDR_EN_OUT_15_8]), 32'h5A);
    chk("periph_en_pwm_15_8", 32'(periph[ADDR_EN_PWM_15_8]), 32'hC3);
    // reset mid-frame, then a clean frame
    reset_mid_frame();
    run_frame(0, 1'b1, ADDR_EN_PWM_7_0, 8'h96, 16'($urandom), 1'b0, 16'h0, 1'b0);
    chk("periph_en_pwm_7_0", 32'(periph[ADDR_EN_PWM_7_0]), 32'h96);
    // minimum divider
    run_frame(1, 1'b1, ADDR_EN_PWM_15_8, 8'h55, 16'($urandom), 1'b0, 16'h0, 1'b0);
    // randomized frames on both controllers
    for (int k = 0; k < 8; k++) begin
      sel = int'($urandom_range(0, 1));
      pat = 16'($urandom);
      run_frame(sel, 1'($urandom), 7'($urandom), 8'($urandom), pat, 1'b0, 16'h0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
